// File: rtl/ex_result_buffer_pkg.sv
// ex_result_buffer_pkg
// Shared definitions for the execute-stage result buffer:
//   - default widths for result data, destination tag and instruction code
//   - skid-buffer state encoding (the encoding doubles as the occupancy count)
//   - reset value of the condition-code register, ordered {zf, sf, of}
package ex_result_buffer_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int TAG_W_DEF  = 4;
  localparam int OP_W_DEF   = 4;

  // Encoded so that the state value equals the number of held entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  // After reset the machine looks as if the last result was zero.
  localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/ex_cc_reg.sv
// ex_cc_reg
// Architectural condition-code register with write enable.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset, loads CC_RESET
//   we   - write enable
//   d    - new condition codes {zf, sf, of}
//   q    - current condition codes {zf, sf, of}
module ex_cc_reg
  import ex_result_buffer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [2:0] d,
  output logic [2:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= CC_RESET;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex_result_buffer.sv
// ex_result_buffer
// Two-entry skid buffer between the 64-bit ALU units and the memory stage.
// Holds result, destination tag and instruction code in order, and updates
// the condition-code register when a set_cc result is accepted.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Producers hold their payload stable while valid is high and not
// yet accepted; ready never depends combinationally on the other side's
// valid or ready (in_ready is a flop, out_* come straight from the head).
//
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   in_valid / in_ready       - ALU-side handshake
//   in_valE, in_dstE, in_icode- payload carried to the memory stage
//   in_zf, in_sf, in_of       - ALU flags, written to CC when in_set_cc
//   in_set_cc                 - accepted result updates the CC register
//   out_valid / out_ready     - memory-side handshake
//   out_valE, out_dstE, out_icode - head entry payload
//   flush                     - synchronous squash of held and incoming entries
//   cc_zf, cc_sf, cc_of       - architectural condition codes
//   occupancy                 - entries held (0..2), equal to the FSM state
module ex_result_buffer
  import ex_result_buffer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_valE,
  input  logic              in_zf,
  input  logic              in_sf,
  input  logic              in_of,
  input  logic              in_set_cc,
  input  logic [TAG_W-1:0]  in_dstE,
  input  logic [OP_W-1:0]   in_icode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_valE,
  output logic [TAG_W-1:0]  out_dstE,
  output logic [OP_W-1:0]   out_icode,
  input  logic              flush,
  output logic              cc_zf,
  output logic              cc_sf,
  output logic              cc_of,
  output logic [1:0]        occupancy
);

  buf_state_e state, state_next;

  logic              in_ready_q;
  logic [DATA_W-1:0] h_valE,  s_valE;
  logic [TAG_W-1:0]  h_dstE,  s_dstE;
  logic [OP_W-1:0]   h_icode, s_icode;

  logic accept;
  logic pop;
  logic load_h_in;   // head takes the incoming entry
  logic load_s_in;   // skid takes the incoming entry
  logic load_h_s;    // head takes the skid entry
  logic cc_we;
  logic [2:0] cc_q;

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid & out_ready;

  // Next-state and load controls.
  always_comb begin
    state_next = state;
    load_h_in  = 1'b0;
    load_s_in  = 1'b0;
    load_h_s   = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          load_h_in  = 1'b1;
          state_next = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          load_h_in = 1'b1;
        end else if (accept) begin
          load_s_in  = 1'b1;
          state_next = ST_TWO;
        end else if (pop) begin
          state_next = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so no accept can occur.
        if (pop) begin
          load_h_s   = 1'b1;
          state_next = ST_ONE;
        end
      end
      default: begin
        state_next = ST_EMPTY;
      end
    endcase
    // Flush discards everything, including the entry presented this cycle.
    if (flush) begin
      state_next = ST_EMPTY;
      load_h_in  = 1'b0;
      load_s_in  = 1'b0;
      load_h_s   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_next;
      // Registered copy of (state != TWO) so in_ready has no path from out_ready.
      in_ready_q <= (state_next != ST_TWO);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_valE  <= '0;
      h_dstE  <= '0;
      h_icode <= '0;
    end else if (load_h_in) begin
      h_valE  <= in_valE;
      h_dstE  <= in_dstE;
      h_icode <= in_icode;
    end else if (load_h_s) begin
      h_valE  <= s_valE;
      h_dstE  <= s_dstE;
      h_icode <= s_icode;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_valE  <= '0;
      s_dstE  <= '0;
      s_icode <= '0;
    end else if (load_s_in) begin
      s_valE  <= in_valE;
      s_dstE  <= in_dstE;
      s_icode <= in_icode;
    end
  end

  // CC follows accept time, not pop time; a flushed input never writes it.
  assign cc_we = accept & in_set_cc & ~flush;

  ex_cc_reg u_cc_reg (
    .clk (clk),
    .rst (rst),
    .we  (cc_we),
    .d   ({in_zf, in_sf, in_of}),
    .q   (cc_q)
  );

  assign {cc_zf, cc_sf, cc_of} = cc_q;

  assign in_ready  = in_ready_q;
  assign out_valid = (state != ST_EMPTY);
  assign out_valE  = h_valE;
  assign out_dstE  = h_dstE;
  assign out_icode = h_icode;
  assign occupancy = state;

endmodule

// File: tb/tb_ex_result_buffer.sv
// tb_ex_result_buffer
// Directed bench for ex_result_buffer: reset values, pass-through,
// backpressure, streaming, flush, CC write rules and asynchronous reset.
module tb_ex_result_buffer;

  localparam int DATA_W = 64;
  localparam int TAG_W  = 4;
  localparam int OP_W   = 4;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_valE;
  logic              in_zf, in_sf, in_of, in_set_cc;
  logic [TAG_W-1:0]  in_dstE;
  logic [OP_W-1:0]   in_icode;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_valE;
  logic [TAG_W-1:0]  out_dstE;
  logic [OP_W-1:0]   out_icode;
  logic              flush;
  logic              cc_zf, cc_sf, cc_of;
  logic [1:0]        occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] exp_q[$];

  ex_result_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_valE   (in_valE),
    .in_zf     (in_zf),
    .in_sf     (in_sf),
    .in_of     (in_of),
    .in_set_cc (in_set_cc),
    .in_dstE   (in_dstE),
    .in_icode  (in_icode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_valE  (out_valE),
    .out_dstE  (out_dstE),
    .out_icode (out_icode),
    .flush     (flush),
    .cc_zf     (cc_zf),
    .cc_sf     (cc_sf),
    .cc_of     (cc_of),
    .occupancy (occupancy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking task
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic [DATA_W-1:0] v, input logic zf, input logic sf,
                       input logic of_f, input logic set_cc, input logic [TAG_W-1:0] dst,
                       input logic [OP_W-1:0] icode);
    in_valid  = 1'b1;
    in_valE   = v;
    in_zf     = zf;
    in_sf     = sf;
    in_of     = of_f;
    in_set_cc = set_cc;
    in_dstE   = dst;
    in_icode  = icode;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_set_cc = 1'b0;
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_valE   = '0;
    in_zf     = 1'b0;
    in_sf     = 1'b0;
    in_of     = 1'b0;
    in_set_cc = 1'b0;
    in_dstE   = '0;
    in_icode  = '0;
    out_ready = 1'b0;
    flush     = 1'b0;

    // Reset state
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_occupancy", occupancy, 0);
    check("rst_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
    check("rst_out_valE", out_valE, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Single pass-through
    out_ready = 1'b1;
    drive(64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 4'h3, 4'h6);
    tick();
    idle();
    check("pt_out_valid", out_valid, 1);
    check("pt_out_valE", out_valE, 64'h8000_0000_0000_0000);
    check("pt_out_dstE", out_dstE, 4'h3);
    check("pt_out_icode", out_icode, 4'h6);
    check("pt_cc", {cc_zf, cc_sf, cc_of}, 3'b010);
    tick();
    check("pt_drained", out_valid, 0);
    check("pt_occ0", occupancy, 0);

    // Backpressure: A, B fill; C ignored
    out_ready = 1'b0;
    drive(64'h1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 4'h2);
    tick();
    drive(64'h2, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 4'h2);
    tick();
    check("bp_occ2", occupancy, 2);
    check("bp_in_ready", in_ready, 0);
    check("bp_head_a", out_valE, 64'h1);
    drive(64'h3, 1'b1, 1'b1, 1'b1, 1'b1, 4'h4, 4'h2);
    tick();
    idle();
    check("bp_occ_still2", occupancy, 2);
    check("bp_head_still_a", out_valE, 64'h1);
    check("bp_cc_unchanged", {cc_zf, cc_sf, cc_of}, 3'b010);
    out_ready = 1'b1;
    tick();
    check("bp_head_b", out_valE, 64'h2);
    check("bp_dst_b", out_dstE, 4'h2);
    check("bp_occ1", occupancy, 1);
    check("bp_in_ready_back", in_ready, 1);
    tick();
    check("bp_no_c", out_valid, 0);

    // Streaming: accept and pop every cycle
    for (int i = 0; i < 8; i++) begin
      logic [DATA_W-1:0] v;
      v = 64'hA0 + 64'(i) * 64'h1_0000_0001;
      drive(v, 1'b0, 1'b0, 1'b0, 1'b0, 4'(i), 4'h7);
      exp_q.push_back(v);
      tick();
      check("st_out_valid", out_valid, 1);
      check("st_occ1", occupancy, 1);
      if (exp_q.size() != 0) check("st_order", out_valE, exp_q.pop_front());
    end
    idle();
    tick();
    check("st_drained", out_valid, 0);
    check("st_queue_empty", exp_q.size(), 0);

    // Flush at TWO with an offered set_cc input
    out_ready = 1'b0;
    drive(64'h11, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 4'h1);
    tick();
    drive(64'h22, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6, 4'h1);
    tick();
    check("fl_occ2", occupancy, 2);
    drive(64'h33, 1'b0, 1'b0, 1'b1, 1'b1, 4'h7, 4'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    check("fl_out_valid", out_valid, 0);
    check("fl_occ0", occupancy, 0);
    check("fl_in_ready", in_ready, 1);
    check("fl_cc_kept", {cc_zf, cc_sf, cc_of}, 3'b010);

    // Flush at ONE while the input is actually accepted
    drive(64'h44, 1'b0, 1'b0, 1'b0, 1'b0, 4'h8, 4'h1);
    tick();
    drive(64'h55, 1'b1, 1'b0, 1'b1, 1'b1, 4'h9, 4'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    check("fl1_occ0", occupancy, 0);
    check("fl1_cc_kept", {cc_zf, cc_sf, cc_of}, 3'b010);
    tick();
    check("fl1_stays_empty", out_valid, 0);

    // Zero-result CC then a non-set_cc result
    out_ready = 1'b1;
    drive(64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 4'hA, 4'h3);
    tick();
    check("zc_cc_after_zero", {cc_zf, cc_sf, cc_of}, 3'b100);
    check("zc_head_zero", out_valE, 64'h0);
    drive(64'h5, 1'b0, 1'b0, 1'b1, 1'b0, 4'hB, 4'h3);
    tick();
    idle();
    check("zc_cc_kept", {cc_zf, cc_sf, cc_of}, 3'b100);
    check("zc_head_five", out_valE, 64'h5);
    check("zc_occ1", occupancy, 1);
    tick();

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    drive(64'h77, 1'b0, 1'b1, 1'b1, 1'b1, 4'hC, 4'h4);
    tick();
    drive(64'h88, 1'b0, 1'b1, 1'b1, 1'b1, 4'hD, 4'h4);
    tick();
    idle();
    check("ar_pre_occ2", occupancy, 2);
    check("ar_pre_cc", {cc_zf, cc_sf, cc_of}, 3'b011);
    #3;
    rst = 1'b1;
    #1;
    check("ar_occ0", occupancy, 0);
    check("ar_out_valid", out_valid, 0);
    check("ar_in_ready", in_ready, 1);
    check("ar_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
    check("ar_out_valE", out_valE, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("ar_post_empty", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
